level_ctrl: RTL and testbench
=============================

# level_ctrl

Upstream level controller for the variable-rate clock divider. It turns two raw push-buttons (up/down) and an optional auto-advance mechanism, driven by ticks of the divided game clock, into the registered 4-bit level word that feeds the divider's `In` select. The level saturates within a legal range, so the divider's test-only code 15 (50 MHz) is never produced in normal play.

## Interface
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable `Clk` cycles required before a button change is accepted (10 ms at 100 MHz); must be ≥ 2.
- `TICKS_PER_LEVEL`, 32: rising edges of `Tick` per automatic level increment; must be ≥ 1.
- `LEVEL_MIN`, 1: lowest level and the reset level.
- `LEVEL_MAX`, 14: highest level. Requires `LEVEL_MIN` < `LEVEL_MAX` ≤ 14.

- `Clk`  in  1  system clock; single clock domain.
- `Rst`  in  1  synchronous, active-high reset.
- `BtnUp`  in  1  raw, asynchronous up button, active-high.
- `BtnDown`  in  1  raw, asynchronous down button, active-high.
- `Tick`  in  1  divided clock (`ClkOut` of the divider); registered on `Clk`, so no synchronizer is needed.
- `AutoEn`  in  1  enables auto-advance.
- `Level`  out  4  current level; connects to divider `In`.
- `LevelChg`  out  1  one-cycle pulse in the first cycle a new `Level` is visible.
- `AtMax`  out  1  high while `Level == LEVEL_MAX`.

## Operation
- Button path (identical for each button): 2-FF synchronizer (`s1`, `s2`), then debounce:
  - if `s2 != state`, `cnt` increments;
  - when `cnt == DEBOUNCE_CYCLES-1` and `s2 != state`: `state <= s2`, `cnt <= 0`;
  - if `s2 == state`: `cnt <= 0`.
- Press = `state & ~state_d` (rising edge of the debounced state), one cycle. Releases generate nothing.
- Tick path: `TickD <= Tick`; `TickRise = Tick & ~TickD`. `TickCnt` (width clog2(`TICKS_PER_LEVEL`), min 1) counts `TickRise` only while `AutoEn` is high and `Level < LEVEL_MAX`. When `AutoEn` is low, `TickCnt` holds its value.
- Level update priority per cycle:
  1. `Rst`: `Level <= LEVEL_MIN`; all counters, sync flops, debounced states, `TickD` and `TickCnt` cleared.
  2. Up press and down press in the same cycle: no change, `TickCnt` unchanged.
  3. Up press: `Level` + 1 unless at `LEVEL_MAX`; `TickCnt <= 0`.
  4. Down press: `Level` − 1 unless at `LEVEL_MIN`; `TickCnt <= 0`.
  5. Auto: if `TickRise` and `TickCnt == TICKS_PER_LEVEL-1`, then `Level` + 1 and `TickCnt <= 0`; otherwise `TickCnt` + 1 on `TickRise`.
- Up press coincident with an auto-increment gives a single +1 only, and `TickCnt` clears.
- Saturation: a press at a limit leaves `Level` unchanged, and `LevelChg` stays low. `TickCnt` still clears.
- At `LEVEL_MAX`, auto-advance stops and `TickCnt` holds at 0.

## Timing
- Reset values: `Level = LEVEL_MIN`, `LevelChg = 0`, `AtMax = 0`.
- Button latency: if `BtnUp` is first sampled high at edge E0 and held, `s2` rises at E1, `state` at E1+`DEBOUNCE_CYCLES`, and `Level` updates at E0+`DEBOUNCE_CYCLES`+2.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles at `s2` produces no press.
- Auto latency: `Level` updates on the same edge that samples the qualifying `TickRise` cycle.
- `LevelChg` is registered and asserts on the same edge `Level` changes; it is high exactly one cycle per change.
- `AtMax` is decoded from the `Level` register, so it is aligned with `Level`.
- `Rst` asserted mid-debounce or mid-tick-count discards all progress. The first press after reset needs a full debounce period.
- `Level` changes at most once per cycle. The divider re-syncs on its own; `level_ctrl` does not wait on it.

## Structure
- Shared package `icarus_pkg`: `LEVEL_W = 4` and the default level limits `LEVEL_MIN_DEF = 1`, `LEVEL_MAX_DEF = 14`.
- Sub-module `btn_debounce` (synchronizer + debounce + rise pulse, parameter `DEBOUNCE_CYCLES`), instantiated twice. Tick edge detection, the tick counter and the level register stay in `level_ctrl`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`, `TICKS_PER_LEVEL = 3`.
- Reset, then a clean `BtnUp` pulse held 10 cycles: `Level` 1→2 exactly 6 edges after the first high sample; `LevelChg` high for 1 cycle; the release produces no change.
- `BtnUp` glitch high 3 cycles, then low: `Level` stays 1 and `LevelChg` never asserts.
- 13 debounced up presses from level 1: `Level` reaches 14 and `AtMax = 1`. A 14th press leaves `Level = 14` with `LevelChg = 0`. One down press gives 13.
- `AutoEn = 1`, `Tick` toggling every 5 cycles: `Level` +1 on every 3rd `Tick` rising edge. `AutoEn = 0` freezes both `TickCnt` and `Level`.
- Up and down debounced presses landing in the same cycle: `Level` unchanged. Up press coincident with the 3rd `TickRise`: exactly +1 and `TickCnt = 0`.
- `Rst` asserted for 1 cycle at `Level = 9`, mid-debounce and with `TickCnt = 2`: next cycle `Level = 1`, `LevelChg = 0`. A subsequent up press needs the full 6-edge latency.

Source files
------------

// File: rtl/icarus_pkg.sv
// Shared definitions for the game-clock level controller and its helpers.
package icarus_pkg;

    localparam int LEVEL_W       = 4;
    localparam int LEVEL_MIN_DEF = 1;
    localparam int LEVEL_MAX_DEF = 14;

    // What the level register does on a given cycle
    typedef enum logic [1:0] {
        LVL_HOLD,
        LVL_INC,
        LVL_DEC
    } levelAction_e;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int cntWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-FF synchronizer, stability debounce and a
// one-cycle pulse on the rising edge of the debounced state.
module btn_debounce
    import icarus_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Btn,
    output logic Press
);

    localparam int                CNT_W   = cntWidth(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             state;
    logic             stateD;
    logic [CNT_W-1:0] cnt;

    // Synchronize the button, then accept a new value only after it has
    // disagreed with the debounced state for DEBOUNCE_CYCLES straight cycles
    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            state  <= 1'b0;
            stateD <= 1'b0;
            cnt    <= '0;
        end else begin
            s1     <= Btn;
            s2     <= s1;
            stateD <= state;
            if (s2 != state) begin
                if (cnt == CNT_MAX) begin
                    state <= s2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign Press = state & ~stateD;

endmodule

// File: rtl/level_ctrl.sv
// Level controller: turns debounced up/down presses and divided-clock ticks
// into the saturating 4-bit level word that selects the divider rate.
module level_ctrl
    import icarus_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICKS_PER_LEVEL = 32,
    parameter int LEVEL_MIN       = LEVEL_MIN_DEF,
    parameter int LEVEL_MAX       = LEVEL_MAX_DEF
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               BtnUp,
    input  logic               BtnDown,
    input  logic               Tick,
    input  logic               AutoEn,
    output logic [LEVEL_W-1:0] Level,
    output logic               LevelChg,
    output logic               AtMax
);

    localparam int                  TC_W    = cntWidth(TICKS_PER_LEVEL);
    localparam logic [TC_W-1:0]     TC_LAST = TC_W'(TICKS_PER_LEVEL - 1);
    localparam logic [LEVEL_W-1:0]  LVL_MIN = LEVEL_W'(LEVEL_MIN);
    localparam logic [LEVEL_W-1:0]  LVL_MAX = LEVEL_W'(LEVEL_MAX);

    logic            upPress;
    logic            downPress;
    logic            tickD;
    logic            tickRise;
    logic [TC_W-1:0] tickCnt;
    logic [TC_W-1:0] tickCntNext;
    levelAction_e    action;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) upBtn (
        .Clk   (Clk),
        .Rst   (Rst),
        .Btn   (BtnUp),
        .Press (upPress)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) downBtn (
        .Clk   (Clk),
        .Rst   (Rst),
        .Btn   (BtnDown),
        .Press (downPress)
    );

    assign tickRise = Tick & ~tickD;
    assign AtMax    = (Level == LVL_MAX);

    // Decide this cycle's level action; presses outrank auto-advance, and
    // opposing presses cancel each other without touching the tick count
    always_comb begin
        action      = LVL_HOLD;
        tickCntNext = tickCnt;
        if (upPress && downPress) begin
            action      = LVL_HOLD;
        end else if (upPress) begin
            tickCntNext = '0;
            if (Level != LVL_MAX) begin
                action = LVL_INC;
            end
        end else if (downPress) begin
            tickCntNext = '0;
            if (Level != LVL_MIN) begin
                action = LVL_DEC;
            end
        end else if (AutoEn && (Level < LVL_MAX) && tickRise) begin
            if (tickCnt == TC_LAST) begin
                action      = LVL_INC;
                tickCntNext = '0;
            end else begin
                tickCntNext = tickCnt + TC_W'(1);
            end
        end
    end

    // Level register, change pulse, tick edge history and tick counter
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Level    <= LVL_MIN;
            LevelChg <= 1'b0;
            tickD    <= 1'b0;
            tickCnt  <= '0;
        end else begin
            tickD    <= Tick;
            tickCnt  <= tickCntNext;
            LevelChg <= (action != LVL_HOLD);
            case (action)
                LVL_INC: Level <= Level + LEVEL_W'(1);
                LVL_DEC: Level <= Level - LEVEL_W'(1);
                default: Level <= Level;
            endcase
        end
    end

endmodule

// File: tb/tb_level_ctrl.sv
// Self-checking bench for level_ctrl with short debounce and tick periods.
module tb_level_ctrl;
    import icarus_pkg::*;

    localparam int DC   = 4;
    localparam int TPL  = 3;
    localparam int LMIN = 1;
    localparam int LMAX = 14;

    logic               Clk     = 1'b0;
    logic               Rst     = 1'b0;
    logic               BtnUp   = 1'b0;
    logic               BtnDown = 1'b0;
    logic               Tick    = 1'b0;
    logic               AutoEn  = 1'b0;
    logic [LEVEL_W-1:0] Level;
    logic               LevelChg;
    logic               AtMax;

    int checks = 0;
    int errors = 0;

    bit gAuto  = 1'b0;
    bit gTick  = 1'b0;
    bit sawChg = 1'b0;

    level_ctrl #(
        .DEBOUNCE_CYCLES (DC),
        .TICKS_PER_LEVEL (TPL),
        .LEVEL_MIN       (LMIN),
        .LEVEL_MAX       (LMAX)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .BtnUp    (BtnUp),
        .BtnDown  (BtnDown),
        .Tick     (Tick),
        .AutoEn   (AutoEn),
        .Level    (Level),
        .LevelChg (LevelChg),
        .AtMax    (AtMax)
    );

    // 100 MHz-style free-running clock
    always #5 Clk = ~Clk;

    // Reference model: a button is accepted once the synchronized samples of
    // the last DC edges all disagree with the accepted value and at least DC
    // edges have passed since the last acceptance; hist[k] is the raw sample
    // taken k+1 edges ago.
    typedef struct {
        logic [DC:0] hist;
        int          sinceFlip;
        bit          st;
        bit          pend;
    } btnModel_t;

    btnModel_t mUp;
    btnModel_t mDn;
    int        mLevel;
    int        mTicks;
    bit        mTickPrev;
    bit        mChg;

    function automatic void btnReset(output btnModel_t b);
        b.hist      = '0;
        b.sinceFlip = 0;
        b.st        = 1'b0;
        b.pend      = 1'b0;
    endfunction

    function automatic void btnStep(inout btnModel_t b, input bit raw);
        bit flip;
        flip = 1'b0;
        b.sinceFlip++;
        if (b.sinceFlip >= DC) begin
            flip = 1'b1;
            for (int j = 1; j <= DC; j++)
                if (b.hist[j] == b.st) flip = 1'b0;
        end
        b.pend = flip && !b.st;
        if (flip) begin
            b.st        = !b.st;
            b.sinceFlip = 0;
        end
        b.hist = {b.hist[DC-1:0], raw};
    endfunction

    function automatic void modelEdge(bit rst, bit up, bit dn, bit tk, bit au);
        bit upP, dnP, rise;
        if (rst) begin
            btnReset(mUp);
            btnReset(mDn);
            mLevel    = LMIN;
            mTicks    = 0;
            mTickPrev = 1'b0;
            mChg      = 1'b0;
            return;
        end
        upP = mUp.pend;
        dnP = mDn.pend;
        btnStep(mUp, up);
        btnStep(mDn, dn);
        rise      = tk && !mTickPrev;
        mTickPrev = tk;
        mChg      = 1'b0;
        if (upP && dnP) begin
            mChg = 1'b0;
        end else if (upP) begin
            mTicks = 0;
            if (mLevel < LMAX) begin mLevel++; mChg = 1'b1; end
        end else if (dnP) begin
            mTicks = 0;
            if (mLevel > LMIN) begin mLevel--; mChg = 1'b1; end
        end else if (au && mLevel < LMAX && rise) begin
            mTicks++;
            if (mTicks == TPL) begin
                mLevel++;
                mTicks = 0;
                mChg   = 1'b1;
            end
        end
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic checkOutput();
        check("level", int'(Level), mLevel);
        check("levelChg", int'(LevelChg), int'(mChg));
        check("atMax", int'(AtMax), int'(mLevel == LMAX));
        if (LevelChg) sawChg = 1'b1;
    endtask

    task automatic applyStimulus(bit rst, bit up, bit dn, bit tk, bit au);
        Rst     = rst;
        BtnUp   = up;
        BtnDown = dn;
        Tick    = tk;
        AutoEn  = au;
        @(posedge Clk);
        modelEdge(rst, up, dn, tk, au);
        #1;
        checkOutput();
    endtask

    task automatic step(bit up, bit dn);
        applyStimulus(1'b0, up, dn, gTick, gAuto);
    endtask

    task automatic doReset();
        gTick = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, gAuto);
    endtask

    task automatic pressBtn(bit up, bit dn);
        repeat (DC + 3) step(up, dn);
        repeat (DC + 3) step(1'b0, 1'b0);
    endtask

    task automatic tickPulse();
        gTick = 1'b1; step(1'b0, 1'b0); step(1'b0, 1'b0);
        gTick = 1'b0; step(1'b0, 1'b0); step(1'b0, 1'b0);
    endtask

    typedef struct {
        bit rst, up, dn, tk, au;
        int expLevel;
        bit expChg;
    } vec_t;

    function automatic vec_t mkVec(bit rst, bit up, int lvl, bit chg);
        vec_t v;
        v.rst = rst; v.up = up; v.dn = 1'b0; v.tk = 1'b0; v.au = 1'b0;
        v.expLevel = lvl;
        v.expChg   = chg;
        return v;
    endfunction

    vec_t vecs[$];
    int   latency;
    int   lvlSnap;

    initial begin
        $display("[TB] level_ctrl bench start");

        // Clean press held 10 cycles: level 2 exactly 6 edges after first sample
        vecs.push_back(mkVec(1'b1, 1'b0, 1, 1'b0));
        for (int k = 1; k <= 18; k++)
            vecs.push_back(mkVec(1'b0, k <= 10, (k >= 7) ? 2 : 1, k == 7));
        // Three-cycle glitch never becomes a press
        vecs.push_back(mkVec(1'b1, 1'b0, 1, 1'b0));
        for (int k = 1; k <= 11; k++)
            vecs.push_back(mkVec(1'b0, k <= 3, 1, 1'b0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].up, vecs[i].dn, vecs[i].tk, vecs[i].au);
            check("vecLevel", int'(Level), vecs[i].expLevel);
            check("vecChg", int'(LevelChg), int'(vecs[i].expChg));
        end

        // Saturation at the top, then one step down
        gAuto = 1'b0;
        doReset();
        repeat (13) pressBtn(1'b1, 1'b0);
        check("reach14", int'(Level), 14);
        check("atMax14", int'(AtMax), 1);
        sawChg = 1'b0;
        pressBtn(1'b1, 1'b0);
        check("satLevel", int'(Level), 14);
        check("satChg", int'(sawChg), 0);
        pressBtn(1'b0, 1'b1);
        check("downTo13", int'(Level), 13);

        // Auto-advance every 3rd tick rise, freeze while disabled
        doReset();
        gAuto = 1'b1;
        for (int c = 0; c < 100; c++) begin
            gTick = ((c / 5) % 2) == 1;
            step(1'b0, 1'b0);
        end
        check("autoLevel", int'(Level), 4);
        gAuto = 1'b0;
        for (int c = 100; c < 150; c++) begin
            gTick = ((c / 5) % 2) == 1;
            step(1'b0, 1'b0);
        end
        check("frozenLevel", int'(Level), 4);
        gAuto = 1'b1;
        for (int c = 150; c < 170; c++) begin
            gTick = ((c / 5) % 2) == 1;
            step(1'b0, 1'b0);
        end
        check("resumeLevel", int'(Level), 5);

        // Opposing presses in the same cycle cancel
        gAuto = 1'b0;
        doReset();
        pressBtn(1'b1, 1'b0);
        pressBtn(1'b1, 1'b0);
        pressBtn(1'b1, 1'b1);
        check("bothPress", int'(Level), 3);

        // Up press on the same edge as the 3rd tick rise: single +1, count cleared
        doReset();
        gAuto = 1'b1;
        tickPulse();
        tickPulse();
        for (int c = 0; c < 16; c++) begin
            gTick = (c == 6) || (c == 7);
            step(c < 10, 1'b0);
        end
        check("coincidentInc", int'(Level), 2);
        tickPulse();
        tickPulse();
        check("countCleared", int'(Level), 2);
        tickPulse();
        check("thirdAfterClear", int'(Level), 3);

        // Reset mid-debounce with partial tick count discards all progress
        gAuto = 1'b0;
        doReset();
        repeat (8) pressBtn(1'b1, 1'b0);
        check("reach9", int'(Level), 9);
        gAuto = 1'b1;
        tickPulse();
        tickPulse();
        repeat (3) step(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, gAuto);
        check("rstLevel", int'(Level), 1);
        check("rstChg", int'(LevelChg), 0);
        latency = -1;
        for (int n = 1; n <= 12; n++) begin
            step(1'b1, 1'b0);
            if (latency < 0 && Level == 2) latency = n - 1;
        end
        check("postRstLatency", latency, 6);
        repeat (DC + 3) step(1'b0, 1'b0);

        // Randomized traffic against the model
        begin
            bit rUp, rDn;
            rUp = 1'b0; rDn = 1'b0;
            doReset();
            for (int c = 0; c < 1500; c++) begin
                if ($urandom_range(5, 0) == 0) rUp = !rUp;
                if ($urandom_range(6, 0) == 0) rDn = !rDn;
                if ($urandom_range(2, 0) == 0) gTick = !gTick;
                if ($urandom_range(39, 0) == 0) gAuto = !gAuto;
                if ($urandom_range(299, 0) == 0)
                    applyStimulus(1'b1, rUp, rDn, gTick, gAuto);
                else
                    step(rUp, rDn);
            end
        end
        lvlSnap = int'(Level);
        check("finalModel", lvlSnap, mLevel);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
